ula_multiciclo: RTL and testbench

// - Parametrised successor of the single-cycle 8-bit ULA. Adds a registered result, a start/valid

---
 rtl/ula_pkg.sv | 19 +
 rtl/ula_muldiv_iter.sv | 81 ++++++++
 rtl/ula_multiciclo.sv | 138 +++++++++++++
 tb/tb_ula_multiciclo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared opcode and FSM encodings for the multicycle ULA.
package ula_pkg;

  localparam logic [2:0] ULA_ADD  = 3'b000;
  localparam logic [2:0] ULA_SUB  = 3'b001;
  localparam logic [2:0] ULA_SLT  = 3'b010;
  localparam logic [2:0] ULA_SLTU = 3'b011;
  localparam logic [2:0] ULA_AND  = 3'b100;
  localparam logic [2:0] ULA_OR   = 3'b101;
  localparam logic [2:0] ULA_MUL  = 3'b110;
  localparam logic [2:0] ULA_DIVU = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    CALC   = 2'b01,
    FIM    = 2'b10
  } estado_t;

endpackage

// File: rtl/ula_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step per cycle.
// done flags the final step; result is the value that step produces, ready to be registered.
module ula_muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic             div_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]   rsh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] sreg_nx;
  logic [WIDTH-1:0] opnd_nx;

  // acc is the product accumulator or the partial remainder; sreg holds the multiplier
  // or the dividend bits that are progressively replaced by quotient bits.
  always_comb begin
    rsh     = {acc, sreg[WIDTH-1]};
    diff    = rsh - {1'b0, opnd};
    acc_nx  = acc;
    sreg_nx = sreg;
    opnd_nx = opnd;
    if (div_q) begin
      if (!diff[WIDTH]) begin
        acc_nx  = diff[WIDTH-1:0];
        sreg_nx = {sreg[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx  = rsh[WIDTH-1:0];
        sreg_nx = {sreg[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nx  = sreg[0] ? acc + opnd : acc;
      sreg_nx = sreg >> 1;
      opnd_nx = opnd << 1;
    end
  end

  assign done   = busy && (cnt == '0);
  assign result = div_q ? sreg_nx : acc_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      sreg  <= '0;
      opnd  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      div_q <= op_div;
      cnt   <= CW'(WIDTH - 1);
      acc   <= '0;
      sreg  <= op_div ? opa : opb;
      opnd  <= op_div ? opb : opa;
    end else if (busy) begin
      acc  <= acc_nx;
      sreg <= sreg_nx;
      opnd <= opnd_nx;
      cnt  <= cnt - CW'(1);
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Multicycle ULA: start/valid handshake, registered result and N/Z/C/V/DivZero flags,
// single-cycle logic/arithmetic ops plus iterative MUL/DIVU.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Inicio,
  input  logic [2:0]       ULAOp,
  input  logic [WIDTH-1:0] Dado1,
  input  logic [WIDTH-1:0] Dado2,
  output logic             Pronto,
  output logic             Valido,
  output logic [WIDTH-1:0] SaidaULA,
  output logic             Zero,
  output logic             Negativo,
  output logic             Carry,
  output logic             Overflow,
  output logic             DivZero
);

  localparam int M = WIDTH - 1;

  estado_t          estado;
  logic             dz_pend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             is_muldiv;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  // Unknown or unlisted opcodes fall into the default branch and behave as AND.
  always_comb begin
    sum     = {1'b0, Dado1} + {1'b0, Dado2};
    dif     = {1'b0, Dado1} - {1'b0, Dado2};
    alu_res = Dado1 & Dado2;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ULAOp)
      ULA_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (Dado1[M] == Dado2[M]) && (sum[M] != Dado1[M]);
      end
      ULA_SUB: begin
        alu_res = dif[WIDTH-1:0];
        alu_c   = dif[WIDTH];
        alu_v   = (Dado1[M] != Dado2[M]) && (dif[M] != Dado1[M]);
      end
      ULA_SLT:  alu_res = WIDTH'($signed(Dado1) < $signed(Dado2));
      ULA_SLTU: alu_res = WIDTH'(Dado1 < Dado2);
      ULA_OR:   alu_res = Dado1 | Dado2;
      ULA_MUL,
      ULA_DIVU: alu_res = '0;
      default:  alu_res = Dado1 & Dado2;
    endcase
  end

  assign is_muldiv = MULDIV_EN && ((ULAOp == ULA_MUL) || (ULAOp == ULA_DIVU));
  assign md_start  = (estado == OCIOSO) && Inicio && is_muldiv;

  ula_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op_div (ULAOp[0]),
    .opa    (Dado1),
    .opb    (Dado2),
    .done   (md_done),
    .result (md_result)
  );

  // Result and flags change only on the edge that enters FIM and are held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= OCIOSO;
      Pronto   <= 1'b1;
      Valido   <= 1'b0;
      SaidaULA <= '0;
      Zero     <= 1'b0;
      Negativo <= 1'b0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      DivZero  <= 1'b0;
      dz_pend  <= 1'b0;
    end else begin
      Valido <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (Inicio) begin
            Pronto <= 1'b0;
            if (is_muldiv) begin
              estado  <= CALC;
              dz_pend <= (ULAOp == ULA_DIVU) && (Dado2 == '0);
            end else begin
              estado   <= FIM;
              Valido   <= 1'b1;
              SaidaULA <= alu_res;
              Zero     <= (alu_res == '0);
              Negativo <= alu_res[M];
              Carry    <= alu_c;
              Overflow <= alu_v;
              DivZero  <= 1'b0;
            end
          end
        end
        CALC: begin
          if (md_done) begin
            estado   <= FIM;
            Valido   <= 1'b1;
            SaidaULA <= md_result;
            Zero     <= (md_result == '0);
            Negativo <= md_result[M];
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            DivZero  <= dz_pend;
          end
        end
        FIM: begin
          estado <= OCIOSO;
          Pronto <= 1'b1;
        end
        default: begin
          estado <= OCIOSO;
          Pronto <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Randomised and directed bench for ula_multiciclo (WIDTH=8) against an arithmetic reference model.
module tb_ula_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Inicio;
  logic [2:0] ULAOp;
  logic [7:0] Dado1;
  logic [7:0] Dado2;
  logic       Pronto;
  logic       Valido;
  logic [7:0] SaidaULA;
  logic       Zero;
  logic       Negativo;
  logic       Carry;
  logic       Overflow;
  logic       DivZero;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int validCycle = 0;

  typedef struct {
    int unsigned res;
    bit z, n, c, v, dz;
    int lat;
  } exp_t;

  ula_multiciclo #(.WIDTH(8), .MULDIV_EN(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Inicio   (Inicio),
    .ULAOp    (ULAOp),
    .Dado1    (Dado1),
    .Dado2    (Dado2),
    .Pronto   (Pronto),
    .Valido   (Valido),
    .SaidaULA (SaidaULA),
    .Zero     (Zero),
    .Negativo (Negativo),
    .Carry    (Carry),
    .Overflow (Overflow),
    .DivZero  (DivZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(int unsigned op, int unsigned a, int unsigned b);
    exp_t e;
    int sa, sb, s;
    sa = (a > 127) ? int'(a) - 256 : int'(a);
    sb = (b > 127) ? int'(b) - 256 : int'(b);
    e = '{res: 0, z: 0, n: 0, c: 0, v: 0, dz: 0, lat: 1};
    case (op)
      0: begin s = sa + sb; e.res = (a + b) % 256; e.c = (a + b) > 255; e.v = (s > 127) || (s < -128); end
      1: begin s = sa - sb; e.res = (a + 256 - b) % 256; e.c = a < b; e.v = (s > 127) || (s < -128); end
      2: e.res = (sa < sb) ? 1 : 0;
      3: e.res = (a < b) ? 1 : 0;
      4: e.res = a & b;
      5: e.res = a | b;
      6: begin e.res = (a * b) % 256; e.lat = 9; end
      default: begin
        e.lat = 9;
        if (b == 0) begin e.res = 255; e.dz = 1; end
        else e.res = a / b;
      end
    endcase
    e.z = (e.res == 0);
    e.n = (e.res >= 128);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic waitPronto(input string tag);
    int n = 0;
    while (Pronto !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_pronto"}, {31'd0, Pronto}, 32'd1);
  endtask

  // Issue one operation, optionally pulse Inicio mid-CALC, and check the response.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input bit pulseInicio, input string tag);
    exp_t e;
    int lat;
    e = model(op, a, b);
    waitPronto(tag);
    Inicio = 1'b1; ULAOp = op; Dado1 = a; Dado2 = b;
    assert (!$isunknown(ULAOp)) else begin
      errors++;
      $error("[TB] FAIL %s ulaop_unknown observed %b", tag, ULAOp);
    end
    @(negedge clk);
    Inicio = 1'b0;
    Dado1 = 8'($urandom);
    Dado2 = 8'($urandom);
    ULAOp = 3'($urandom);
    lat = 1;
    while (Valido !== 1'b1 && lat < 50) begin
      if (pulseInicio && lat == 3) begin
        checkOutput({tag, "_busy"}, {31'd0, Pronto}, 32'd0);
        Inicio = 1'b1; ULAOp = 3'b000;
      end else begin
        Inicio = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    Inicio = 1'b0;
    validCycle = cycle;
    checkOutput({tag, "_lat"}, lat, e.lat);
    checkOutput({tag, "_res"}, {24'd0, SaidaULA}, e.res);
    checkOutput({tag, "_flags"}, {27'd0, Zero, Negativo, Carry, Overflow, DivZero},
                {27'd0, e.z, e.n, e.c, e.v, e.dz});
    @(negedge clk);
    checkOutput({tag, "_hold"}, {23'd0, Valido, SaidaULA}, {23'd0, 1'b0, e.res[7:0]});
  endtask

  initial begin
    int pulses;
    int firstValid;
    logic [2:0] rop;
    logic [7:0] ra, rb;

    rst_n = 1'b0; Inicio = 1'b0; ULAOp = 3'b000; Dado1 = 8'h00; Dado2 = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", {30'd0, Pronto, Valido}, 32'd2);
    checkOutput("reset_data", {19'd0, SaidaULA, Zero, Negativo, Carry, Overflow, DivZero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(3'b000, 8'h7F, 8'h01, 1'b0, "add_ovf");

    // Abort a MUL three cycles after acceptance.
    waitPronto("rst_mul");
    Inicio = 1'b1; ULAOp = 3'b110; Dado1 = 8'd13; Dado2 = 8'd11;
    @(negedge clk);
    Inicio = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ctrl", {30'd0, Pronto, Valido}, 32'd2);
    checkOutput("rst_mid_data", {19'd0, SaidaULA, Zero, Negativo, Carry, Overflow, DivZero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (Valido === 1'b1) pulses++;
    end
    checkOutput("rst_mid_novalid", pulses, 0);

    applyStimulus(3'b110, 8'd13, 8'd11, 1'b1, "mul_13x11");
    applyStimulus(3'b001, 8'h05, 8'h05, 1'b0, "sub_zero");
    applyStimulus(3'b001, 8'h03, 8'h05, 1'b0, "sub_borrow");
    applyStimulus(3'b010, 8'hFF, 8'h01, 1'b0, "slt");
    applyStimulus(3'b011, 8'hFF, 8'h01, 1'b0, "sltu");
    applyStimulus(3'b111, 8'd200, 8'd7, 1'b0, "divu");
    applyStimulus(3'b111, 8'd93, 8'd0, 1'b0, "divu_zero");
    applyStimulus(3'b000, 8'hF0, 8'h20, 1'b0, "add_carry");

    applyStimulus(3'b000, 8'h12, 8'h34, 1'b0, "b2b_add");
    firstValid = validCycle;
    applyStimulus(3'b100, 8'hF0, 8'h3C, 1'b0, "b2b_and");
    checkOutput("b2b_spacing", validCycle - firstValid, 2);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = (i % 6 == 5) ? 8'h00 : 8'($urandom);
      applyStimulus(rop, ra, rb, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
